uart_rx_fifo_gen2: RTL and testbench

UART_RX_FIFO_GEN2 -- requirements
Module: uart_rx_fifo_gen2

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_sync_fifo.sv | 80 ++++++++
 rtl/uart_rx_fifo_gen2.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo_gen2.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and entry layout helpers for the UART receiver
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BREAK_WAIT
  } rx_state_e;

  // Entry layout is {FE, PE, BE, data[DATA_BITS-1:0]}
  function automatic int entry_width(input int data_bits);
    return data_bits + 3;
  endfunction

  function automatic int be_idx(input int data_bits);
    return data_bits;
  endfunction

  function automatic int pe_idx(input int data_bits);
    return data_bits + 1;
  endfunction

  function automatic int fe_idx(input int data_bits);
    return data_bits + 2;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word-fall-through FIFO with flush and full-bypass push/pop
module uart_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == NW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a paired push
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  // Next pointer, count and storage values; flush overrides everything
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_gen2.sv
// rtl/uart_rx_fifo_gen2.sv - oversampling UART receiver with error flags and receive FIFO
module uart_rx_fifo_gen2
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                            baud_clk,
  input  logic                            rst,
  input  logic                            data_in,
  input  logic                            parity_en,
  input  logic                            parity_odd,
  input  logic                            two_stop,
  input  logic                            receive_order,
  input  logic                            flush,
  output logic [DATA_BITS+2:0]            data_out,
  output logic                            RxFE,
  output logic                            RxFF,
  output logic                            Rx_ready_APB,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            OE
);

  localparam int EW     = entry_width(DATA_BITS);
  localparam int FE_IDX = fe_idx(DATA_BITS);
  localparam int PE_IDX = pe_idx(DATA_BITS);
  localparam int BE_IDX = be_idx(DATA_BITS);
  localparam int CW     = $clog2(OVERSAMPLE);
  localparam int BW     = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic [1:0]           sync_q, sync_d;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 fe_q, fe_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 two_stop_q, two_stop_d;
  logic                 push_q, push_d;
  logic [EW-1:0]        entry_q, entry_d;
  logic                 oe_q, oe_d;
  logic                 rx_s, pe_calc, brk, sample, ent_fe, ent_be;
  logic                 fifo_full, fifo_empty, pop_ok;

  assign rx_s    = sync_q[1];
  assign sample  = (cnt_q == CNT_LAST);
  assign pe_calc = par_en_q & ((^shift_q ^ par_q) != par_odd_q);
  assign brk     = (shift_q == '0) & (~par_en_q | ~par_q) & ~rx_s;

  // Bit-level receive sequencing; the finished entry is registered and pushed one cycle later
  always_comb begin
    sync_d     = {sync_q[0], data_in};
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    fe_d       = fe_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    push_d     = 1'b0;
    ent_fe     = 1'b0;
    ent_be     = 1'b0;
    entry_d    = entry_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d    = ST_START;
          bit_d      = '0;
          shift_d    = '0;
          par_d      = 1'b0;
          fe_d       = 1'b0;
          par_en_d   = parity_en;
          par_odd_d  = parity_odd;
          two_stop_d = two_stop;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (sample) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (sample) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = ST_STOP1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP1: begin
        if (sample) begin
          cnt_d = '0;
          if (brk) begin
            push_d  = 1'b1;
            ent_fe  = 1'b1;
            ent_be  = 1'b1;
            state_d = ST_BREAK_WAIT;
          end else if (two_stop_q) begin
            fe_d    = ~rx_s;
            state_d = ST_STOP2;
          end else begin
            push_d  = 1'b1;
            ent_fe  = ~rx_s;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP2: begin
        if (sample) begin
          cnt_d   = '0;
          push_d  = 1'b1;
          ent_fe  = fe_q | ~rx_s;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BREAK_WAIT: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (push_d) begin
      entry_d                  = '0;
      entry_d[DATA_BITS-1:0]   = shift_q;
      entry_d[FE_IDX]          = ent_fe;
      entry_d[PE_IDX]          = pe_calc;
      entry_d[BE_IDX]          = ent_be;
    end
  end

  // Overrun is sticky until flush; a pop in the push cycle makes room so no overrun
  assign pop_ok = receive_order & ~fifo_empty;
  always_comb begin
    oe_d = oe_q;
    if (flush) begin
      oe_d = 1'b0;
    end else if (push_q && fifo_full && !pop_ok) begin
      oe_d = 1'b1;
    end
  end

  // Receiver state registers; the synchronizer idles high so reset looks like a quiet line
  always_ff @(posedge baud_clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= 2'b11;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      fe_q       <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      push_q     <= 1'b0;
      entry_q    <= '0;
      oe_q       <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      fe_q       <= fe_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      push_q     <= push_d;
      entry_q    <= entry_d;
      oe_q       <= oe_d;
    end
  end

  uart_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (baud_clk),
    .rst_n     (rst),
    .flush     (flush),
    .push      (push_q),
    .push_data (entry_q),
    .pop       (receive_order),
    .pop_data  (data_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign RxFE         = fifo_empty;
  assign RxFF         = fifo_full;
  assign Rx_ready_APB = ~fifo_empty;
  assign OE           = oe_q;

endmodule

// File: tb/tb_uart_rx_fifo_gen2.sv
// tb/tb_uart_rx_fifo_gen2.sv - self-checking bench for uart_rx_fifo_gen2
module tb_uart_rx_fifo_gen2;

  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int OS    = 16;
  localparam int EW    = DB + 3;
  localparam int FRAME_BITS_8N1 = 10;

  logic          baud_clk = 1'b0;
  logic          rst;
  logic          data_in;
  logic          parity_en;
  logic          parity_odd;
  logic          two_stop;
  logic          receive_order;
  logic          flush;
  logic [EW-1:0] data_out;
  logic          RxFE;
  logic          RxFF;
  logic          Rx_ready_APB;
  logic [2:0]    fifo_count;
  logic          OE;

  int total = 0;
  int bad   = 0;
  int fall_at;
  logic [EW-1:0] exp_q[$];

  uart_rx_fifo_gen2 #(
    .DATA_BITS  (DB),
    .FIFO_DEPTH (DEPTH),
    .OVERSAMPLE (OS)
  ) dut (
    .baud_clk      (baud_clk),
    .rst           (rst),
    .data_in       (data_in),
    .parity_en     (parity_en),
    .parity_odd    (parity_odd),
    .two_stop      (two_stop),
    .receive_order (receive_order),
    .flush         (flush),
    .data_out      (data_out),
    .RxFE          (RxFE),
    .RxFF          (RxFF),
    .Rx_ready_APB  (Rx_ready_APB),
    .fifo_count    (fifo_count),
    .OE            (OE)
  );

  always #5 baud_clk = ~baud_clk;

  // Expected entry from the frame-level error rules
  function automatic logic [EW-1:0] model_entry(input logic [DB-1:0] d, input logic pen,
                                                input logic podd, input logic pbit,
                                                input logic s1, input logic s2, input logic two);
    logic be, pe, fe;
    be = (d == 0) && (!pen || !pbit) && !s1;
    pe = pen && ((^d ^ pbit) != podd);
    fe = be || !s1 || (two && !s2);
    return {fe, pe, be, d};
  endfunction

  // Serial bit sequence: start, data LSB first, optional parity, one or two stops
  task automatic frame_bits(input logic [DB-1:0] d, input logic pen, input logic pbit,
                            input logic s1, input logic s2, input logic two,
                            output logic [31:0] bits, output int nb, output int last_stop);
    int idx;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) bits[1+i] = d[i];
    idx = 1 + DB;
    if (pen) begin
      bits[idx] = pbit;
      idx++;
    end
    bits[idx] = s1;
    last_stop = idx;
    idx++;
    if (two) begin
      bits[idx] = s2;
      last_stop = idx;
      idx++;
    end
    nb = idx;
  endtask

  // Drive bits for OS cycles each, then gap_bits of idle high; records the cycle RxFE falls
  task automatic send_bits(input logic [31:0] bits, input int nb, input int gap_bits, input int pop_at);
    logic prev;
    int cyc;
    fall_at = -1;
    prev = RxFE;
    cyc = (nb + gap_bits) * OS;
    for (int n = 0; n < cyc; n++) begin
      data_in = ((n / OS) < nb) ? bits[n / OS] : 1'b1;
      receive_order = (n == pop_at);
      @(posedge baud_clk);
      #1;
      if (fall_at < 0 && prev && !RxFE) fall_at = n + 1;
      prev = RxFE;
    end
    receive_order = 1'b0;
  endtask

  // Send one frame with the given configuration and update the model FIFO
  task automatic send_frame(input logic [DB-1:0] d, input logic pen, input logic podd,
                            input logic pbit, input logic s1, input logic s2, input logic two,
                            input int pop_at);
    logic [31:0] bits;
    int nb, ls;
    parity_en = pen;
    parity_odd = podd;
    two_stop = two;
    frame_bits(d, pen, pbit, s1, s2, two, bits, nb, ls);
    send_bits(bits, nb, 2, pop_at);
    if (pop_at >= 0 && exp_q.size() > 0) void'(exp_q.pop_front());
    if (exp_q.size() < DEPTH) exp_q.push_back(model_entry(d, pen, podd, pbit, s1, s2, two));
  endtask

  task automatic pop_check(input string name);
    logic [EW-1:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    total++;
    if (data_out !== exp) begin
      bad++;
      $display("FAIL %s: data_out=%h expected=%h", name, data_out, exp);
    end
    receive_order = 1'b1;
    @(posedge baud_clk);
    #1;
    receive_order = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    data_in = 1'b1;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    two_stop = 1'b0;
    receive_order = 1'b0;
    flush = 1'b0;
    #22;
    total++;
    if ({RxFE, RxFF, Rx_ready_APB, OE} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_flags: got=%b expected=1000", {RxFE, RxFF, Rx_ready_APB, OE});
    end
    total++;
    if (fifo_count !== 3'd0 || data_out !== '0) begin
      bad++;
      $display("FAIL reset_fifo: count=%0d data_out=%h expected 0/0", fifo_count, data_out);
    end
    @(posedge baud_clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge baud_clk);
    #1;
  endtask

  task automatic test_8n1();
    int exp_fall;
    exp_fall = 4 + OS / 2 + OS * (FRAME_BITS_8N1 - 1);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    total++;
    if (fall_at != exp_fall) begin
      bad++;
      $display("FAIL 8n1_latency: RxFE fell at cycle %0d expected %0d", fall_at, exp_fall);
    end
    total++;
    if (fifo_count !== 3'd1 || Rx_ready_APB !== 1'b1 || data_out !== 11'h0A5) begin
      bad++;
      $display("FAIL 8n1_entry: count=%0d ready=%b data_out=%h expected 1/1/0a5",
               fifo_count, Rx_ready_APB, data_out);
    end
    pop_check("8n1_pop");
    total++;
    if (RxFE !== 1'b1 || data_out !== '0) begin
      bad++;
      $display("FAIL empty_after_pop: RxFE=%b data_out=%h expected 1/000", RxFE, data_out);
    end
    receive_order = 1'b1;
    @(posedge baud_clk);
    #1;
    receive_order = 1'b0;
    total++;
    if (fifo_count !== 3'd0 || OE !== 1'b0) begin
      bad++;
      $display("FAIL pop_on_empty: count=%0d OE=%b expected 0/0", fifo_count, OE);
    end
  endtask

  task automatic test_parity();
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    total++;
    if (data_out !== 11'h203) begin
      bad++;
      $display("FAIL 8e1_parity_error: data_out=%h expected 203", data_out);
    end
    pop_check("8e1_pop");
  endtask

  task automatic test_random();
    logic [DB-1:0] d;
    logic pen, podd, pbit, s1, s2, two;
    int k;
    for (int g = 0; g < 5; g++) begin
      k = $urandom_range(1, 3);
      for (int f = 0; f < k; f++) begin
        d    = ($urandom_range(0, 4) == 0) ? '0 : DB'($urandom);
        pen  = 1'($urandom);
        podd = 1'($urandom);
        pbit = 1'($urandom);
        two  = 1'($urandom);
        s1   = ($urandom_range(0, 3) != 0);
        s2   = ($urandom_range(0, 3) != 0);
        send_frame(d, pen, podd, pbit, s1, s2, two, -1);
      end
      total++;
      if (fifo_count !== 3'(exp_q.size())) begin
        bad++;
        $display("FAIL random_count: count=%0d expected=%0d", fifo_count, exp_q.size());
      end
      while (exp_q.size() > 0) pop_check("random_entry");
    end
  endtask

  task automatic test_break();
    int exp_fall;
    exp_fall = 4 + OS / 2 + OS * (FRAME_BITS_8N1 - 1);
    parity_en = 1'b0;
    two_stop = 1'b0;
    send_bits(32'h0, 3 * FRAME_BITS_8N1, 3 * FRAME_BITS_8N1, -1);
    exp_q.push_back(11'h500);
    total++;
    if (fall_at != exp_fall) begin
      bad++;
      $display("FAIL break_latency: RxFE fell at cycle %0d expected %0d", fall_at, exp_fall);
    end
    total++;
    if (fifo_count !== 3'd1) begin
      bad++;
      $display("FAIL break_single: count=%0d expected 1", fifo_count);
    end
    pop_check("break_entry");
  endtask

  task automatic test_glitch();
    data_in = 1'b0;
    repeat (OS / 4) @(posedge baud_clk);
    #1;
    data_in = 1'b1;
    repeat (3 * FRAME_BITS_8N1 * OS) @(posedge baud_clk);
    #1;
    total++;
    if (RxFE !== 1'b1 || fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL glitch: RxFE=%b count=%0d expected 1/0", RxFE, fifo_count);
    end
  endtask

  task automatic test_overrun();
    logic [EW-1:0] first;
    for (int f = 0; f < DEPTH + 1; f++) begin
      send_frame(DB'(8'h10 + f), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    end
    first = exp_q[0];
    total++;
    if (fifo_count !== 3'(DEPTH) || RxFF !== 1'b1 || OE !== 1'b1) begin
      bad++;
      $display("FAIL overrun_flags: count=%0d RxFF=%b OE=%b expected 4/1/1", fifo_count, RxFF, OE);
    end
    total++;
    if (data_out !== first) begin
      bad++;
      $display("FAIL overrun_head: data_out=%h expected=%h", data_out, first);
    end
    flush = 1'b1;
    @(posedge baud_clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    total++;
    if (RxFE !== 1'b1 || OE !== 1'b0 || fifo_count !== 3'd0 || data_out !== '0) begin
      bad++;
      $display("FAIL flush: RxFE=%b OE=%b count=%0d data_out=%h expected 1/0/0/000",
               RxFE, OE, fifo_count, data_out);
    end
  endtask

  task automatic test_back_to_back();
    int push_cyc;
    push_cyc = 3 + OS / 2 + OS * (FRAME_BITS_8N1 - 1);
    for (int f = 0; f < DEPTH; f++) begin
      send_frame(DB'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    end
    send_frame(DB'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, push_cyc);
    total++;
    if (fifo_count !== 3'(DEPTH) || OE !== 1'b0 || RxFF !== 1'b1) begin
      bad++;
      $display("FAIL full_push_pop: count=%0d OE=%b RxFF=%b expected 4/0/1", fifo_count, OE, RxFF);
    end
    while (exp_q.size() > 0) pop_check("wrap_order");
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_random();
    test_break();
    test_glitch();
    test_overrun();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
